// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered count and status flags,
// one-cycle overflow/underflow error pulses, and configurable
// almost_full / almost_empty thresholds.
//
// Build option: define SYNC_FIFO_FWFT_EN for first-word-fall-through mode,
// where dout always presents the head word while the FIFO is not empty.
// Without it, an accepted read registers the head word into dout and
// dout_valid is high for the single following cycle.
//
// Storage is deliberately not reset; only pointers, count, flags and the
// output register are cleared by the asynchronous reset.

module sync_fifo #(
    parameter int FIFO_WIDTH    = 16,
    parameter int FIFO_DEPTH    = 8,
    parameter int AFULL_THRESH  = FIFO_DEPTH - 2,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [FIFO_WIDTH-1:0]       din,
    input  logic                        rd_en,
    output logic [FIFO_WIDTH-1:0]       dout,
    output logic                        dout_valid,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    // Storage and pointer state; pointers carry one extra wrap bit.
    logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [ADDR_W:0]       r_wr_ptr;
    logic [ADDR_W:0]       r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    // Registered status flags
    logic r_full;
    logic r_empty;
    logic r_afull;
    logic r_aempty;
    logic r_overflow;
    logic r_underflow;

    // Acceptance decisions and next-state values
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [CNT_W-1:0]  w_count_nxt;

    // Acceptance is decided from the flags as they stand this cycle, so a
    // simultaneous read cannot free room for a write when full (and vice
    // versa when empty).
    assign w_wr_acc  = wr_en && !r_full;
    assign w_rd_acc  = rd_en && !r_empty;
    assign w_wr_addr = r_wr_ptr[ADDR_W-1:0];
    assign w_rd_addr = r_rd_ptr[ADDR_W-1:0];

    // Next occupancy: +1 on write only, -1 on read only, otherwise hold
    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage write: only accepted writes touch the array
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[w_wr_addr] <= din;
        end
    end

    // Pointer advance, modulo depth through natural wrap of the extra bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Count and flags are all registered from the next count value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_aempty <= 1'b1;
            r_full   <= 1'b0;
            r_afull  <= 1'b0;
        end else begin
            r_count  <= w_count_nxt;
            r_empty  <= (w_count_nxt == '0);
            r_full   <= (w_count_nxt == CNT_W'(FIFO_DEPTH));
            r_afull  <= (w_count_nxt >= CNT_W'(AFULL_THRESH));
            r_aempty <= (w_count_nxt <= CNT_W'(AEMPTY_THRESH));
        end
    end

    // Error pulses: one cycle after a request that hit a full/empty FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= wr_en && r_full;
            r_underflow <= rd_en && r_empty;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word falls through combinationally; zero while empty
    always_comb begin
        dout       = '0;
        dout_valid = !r_empty;
        if (!r_empty) begin
            dout = r_mem[w_rd_addr];
        end
    end
`else
    logic [FIFO_WIDTH-1:0] r_dout;
    logic                  r_dout_valid;

    // Popped word is captured at the read edge and held until the next read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            r_dout_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_dout <= r_mem[w_rd_addr];
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
`endif

    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_afull;
    assign almost_empty = r_aempty;
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed scenarios plus randomized traffic for sync_fifo,
// checked every cycle against a queue-based reference model.

module tb_sync_fifo;

    localparam int W  = 16;
    localparam int D  = 8;
    localparam int AF = 6;
    localparam int AE = 1;
    localparam int CW = $clog2(D) + 1;
`ifdef SYNC_FIFO_FWFT_EN
    localparam bit FWFT = 1'b1;
`else
    localparam bit FWFT = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          rst   = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [W-1:0]  din   = '0;
    logic [W-1:0]  dout;
    logic          dout_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;

    always #5 clk = ~clk;

    sync_fifo #(
        .FIFO_WIDTH   (W),
        .FIFO_DEPTH   (D),
        .AFULL_THRESH (AF),
        .AEMPTY_THRESH(AE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .din         (din),
        .rd_en       (rd_en),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    // Reference model: a queue of stored words plus the last popped word
    logic [W-1:0] m_q[$];
    logic [W-1:0] m_dout = '0;
    logic         m_dv   = 1'b0;
    logic         m_ovf  = 1'b0;
    logic         m_udf  = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_dout = '0;
            m_dv   = 1'b0;
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
        end else begin
            bit was_full;
            bit was_empty;
            was_full  = (m_q.size() == D);
            was_empty = (m_q.size() == 0);
            m_ovf = wr_en && was_full;
            m_udf = rd_en && was_empty;
            m_dv  = 1'b0;
            if (rd_en && !was_empty) begin
                m_dout = m_q.pop_front();
                m_dv   = 1'b1;
            end
            if (wr_en && !was_full) begin
                m_q.push_back(din);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            int sz;
            logic [W-1:0] e_dout;
            logic         e_dv;
            sz = m_q.size();
            if (FWFT) begin
                e_dout = (sz != 0) ? m_q[0] : '0;
                e_dv   = (sz != 0);
            end else begin
                e_dout = m_dout;
                e_dv   = m_dv;
            end
            chk("model_count",  32'(count),        32'(sz));
            chk("model_empty",  32'(empty),        32'(sz == 0));
            chk("model_full",   32'(full),         32'(sz == D));
            chk("model_afull",  32'(almost_full),  32'(sz >= AF));
            chk("model_aempty", 32'(almost_empty), 32'(sz <= AE));
            chk("model_ovf",    32'(overflow),     32'(m_ovf));
            chk("model_udf",    32'(underflow),    32'(m_udf));
            chk("model_dout",   32'(dout),         32'(e_dout));
            chk("model_dvalid", 32'(dout_valid),   32'(e_dv));
        end
    end

    // Apply one cycle of inputs; returns at the following falling edge
    task automatic step(input logic w, input logic r, input logic [W-1:0] d);
        wr_en = w;
        rd_en = r;
        din   = d;
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_count"},  32'(count),        32'd0);
        chk({tag, "_empty"},  32'(empty),        32'd1);
        chk({tag, "_aempty"}, 32'(almost_empty), 32'd1);
        chk({tag, "_full"},   32'(full),         32'd0);
        chk({tag, "_afull"},  32'(almost_full),  32'd0);
        chk({tag, "_dout"},   32'(dout),         32'd0);
        chk({tag, "_dvalid"}, 32'(dout_valid),   32'd0);
        chk({tag, "_ovf"},    32'(overflow),     32'd0);
        chk({tag, "_udf"},    32'(underflow),    32'd0);
    endtask

    // Asynchronous reset pulse started between clock edges
    task automatic async_reset(input string tag);
        wr_en = 1'b0;
        rd_en = 1'b0;
        #2 rst = 1'b1;
        #1 chk_reset_vals(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int wr_pct;
        int rd_pct;

        #1 rst = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;

        // Fill 0x0001..0x0008, then one write too many
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0, W'(i));
            chk("fill_count",  32'(count),        32'(i));
            chk("fill_aempty", 32'(almost_empty), 32'(i <= 1));
            chk("fill_afull",  32'(almost_full),  32'(i >= 6));
            chk("fill_full",   32'(full),         32'(i == 8));
            chk("fill_dout",   32'(dout),         FWFT ? 32'h1 : 32'h0);
        end
        step(1'b1, 1'b0, 16'h0009);
        chk("ovf_count", 32'(count),    32'd8);
        chk("ovf_pulse", 32'(overflow), 32'd1);
        step(1'b0, 1'b0, '0);
        chk("ovf_clear", 32'(overflow), 32'd0);

        // Drain all eight words in order, then one read too many
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b1, '0);
            chk("drain_dout",   32'(dout),       FWFT ? ((i < 8) ? 32'(i + 1) : 32'd0) : 32'(i));
            chk("drain_dvalid", 32'(dout_valid), FWFT ? 32'(i < 8) : 32'd1);
            chk("drain_empty",  32'(empty),      32'(i == 8));
        end
        step(1'b0, 1'b1, '0);
        chk("udf_pulse", 32'(underflow), 32'd1);
        chk("udf_dout",  32'(dout),      FWFT ? 32'd0 : 32'd8);
        step(1'b0, 1'b0, '0);
        chk("udf_clear",  32'(underflow),  32'd0);
        chk("udf_dvalid", 32'(dout_valid), 32'd0);

        // Write+read while empty: only the write lands
        step(1'b1, 1'b1, 16'h0055);
        chk("wr_rd_empty_count", 32'(count),     32'd1);
        chk("wr_rd_empty_udf",   32'(underflow), 32'd1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, W'(16'h0056 + i));
        chk("steady_start_count", 32'(count), 32'd4);

        // Twenty cycles of write+read at occupancy four, across pointer wrap
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, W'($urandom));
            chk("steady_count", 32'(count), 32'd4);
        end

        // Write+read while full: only the read lands
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, W'($urandom));
        chk("refill_full", 32'(full), 32'd1);
        step(1'b1, 1'b1, 16'hAAAA);
        chk("wr_rd_full_count", 32'(count),    32'd7);
        chk("wr_rd_full_ovf",   32'(overflow), 32'd1);
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b1, '0);
        chk("pre_reset_count", 32'(count), 32'd5);

        // Reset with data inside, then a fresh word becomes the head
        async_reset("midreset");
        step(1'b1, 1'b0, 16'hBEEF);
        chk("beef_count", 32'(count), 32'd1);
        chk("beef_fwft",  32'(dout),  FWFT ? 32'hBEEF : 32'h0);
        step(1'b0, 1'b1, '0);
        chk("beef_read", 32'(dout), FWFT ? 32'h0 : 32'hBEEF);
        step(1'b0, 1'b0, '0);

        // Randomized traffic with shifting bias to reach both extremes
        for (int seg = 0; seg < 6; seg++) begin
            case (seg % 3)
                0:       begin wr_pct = 85; rd_pct = 20; end
                1:       begin wr_pct = 20; rd_pct = 85; end
                default: begin wr_pct = 60; rd_pct = 60; end
            endcase
            if (seg == 4) async_reset("randreset");
            for (int c = 0; c < 400; c++) begin
                step($urandom_range(0, 99) < wr_pct, $urandom_range(0, 99) < rd_pct, W'($urandom));
            end
        end

        step(1'b0, 1'b0, '0);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
